// File: rtl/buscaminas_cursor.sv
// buscaminas_cursor: cursor controller for the Buscaminas board.
// Converts debounced button levels into a registered (x,y) cursor over a
// COLS x ROWS grid (wrapping or saturating at the edges), and offers the
// chosen cell to the game logic through a valid/ready select handshake.
// Optional build macro: BUSCAMINAS_CURSOR_AUTOREPEAT_EN adds hold-to-repeat
// stepping for a single held direction button.
//
// Handshake: sel_valid rises with sel_x/sel_y loaded and both stay stable
// until a cycle with sel_valid=1 and sel_ready=1; sel_valid drops on the
// following cycle. sel_ready is ignored while sel_valid=0. lock or rst drop
// a pending selection without completing the transfer.
module buscaminas_cursor #(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int START_X       = 0,
  parameter int START_Y       = 0,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4,
  localparam int XW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
  localparam int YW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lock,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_sel,
  input  logic          sel_ready,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          moved,
  output logic          sel_valid,
  output logic [XW-1:0] sel_x,
  output logic [YW-1:0] sel_y
);

  if (COLS < 2 || ROWS < 2 || START_X >= COLS || START_Y >= ROWS ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("buscaminas_cursor: invalid parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEL_WAIT = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Button bit order: {sel, right, left, down, up}
  logic [4:0] btn_now, btn_prev, btn_rise;
  logic [3:0] dir_ev;
  logic       step_en, sel_take, sel_done;
  logic       mv_up, mv_down, mv_left, mv_right;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  assign btn_now  = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign btn_rise = btn_now & ~btn_prev;

`ifdef BUSCAMINAS_CURSOR_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1) + 1;
  logic [RW-1:0] rpt_cnt;
  logic          one_dir, idle_ok, rpt_hold, rpt_fire;

  assign idle_ok  = (state == ST_IDLE) && !lock;
  assign one_dir  = ($countones(btn_now[3:0]) == 1) && !btn_sel;
  assign rpt_hold = idle_ok && one_dir && (btn_now == btn_prev) && (rpt_cnt != '0);
  assign rpt_fire = rpt_hold && (rpt_cnt == RW'(REPEAT_DELAY));
  assign dir_ev   = btn_rise[3:0] | (rpt_fire ? btn_now[3:0] : 4'b0000);

  // Repeat counter: cycles since the edge step, folded back after each repeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else if (idle_ok && one_dir && (btn_rise[3:0] != 4'b0000)) begin
      rpt_cnt <= RW'(1);
    end else if (rpt_hold) begin
      rpt_cnt <= rpt_fire ? RW'(REPEAT_DELAY - REPEAT_PERIOD + 1) : rpt_cnt + 1'b1;
    end else begin
      rpt_cnt <= '0;
    end
  end
`else
  assign dir_ev = btn_rise[3:0];
`endif

  // Opposing events on one axis cancel; one per axis gives a diagonal step
  assign mv_up    = dir_ev[0] && !dir_ev[1];
  assign mv_down  = dir_ev[1] && !dir_ev[0];
  assign mv_left  = dir_ev[2] && !dir_ev[3];
  assign mv_right = dir_ev[3] && !dir_ev[2];

  // Candidate next column with wrap or clamp at the board edge
  always_comb begin
    x_nxt = cursor_x;
    if (mv_right) begin
      if (cursor_x == XW'(COLS - 1)) x_nxt = (WRAP != 0) ? '0 : cursor_x;
      else                           x_nxt = cursor_x + 1'b1;
    end else if (mv_left) begin
      if (cursor_x == '0) x_nxt = (WRAP != 0) ? XW'(COLS - 1) : cursor_x;
      else                x_nxt = cursor_x - 1'b1;
    end
  end

  // Candidate next row with wrap or clamp at the board edge
  always_comb begin
    y_nxt = cursor_y;
    if (mv_down) begin
      if (cursor_y == YW'(ROWS - 1)) y_nxt = (WRAP != 0) ? '0 : cursor_y;
      else                           y_nxt = cursor_y + 1'b1;
    end else if (mv_up) begin
      if (cursor_y == '0) y_nxt = (WRAP != 0) ? YW'(ROWS - 1) : cursor_y;
      else                y_nxt = cursor_y - 1'b1;
    end
  end

  // Next-state logic: lock overrides everything, select beats a same-cycle step
  always_comb begin
    state_nxt = state;
    step_en   = 1'b0;
    sel_take  = 1'b0;
    sel_done  = 1'b0;
    if (lock) begin
      state_nxt = ST_LOCKED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_rise[4]) begin
            state_nxt = ST_SEL_WAIT;
            sel_take  = 1'b1;
          end else begin
            step_en = 1'b1;
          end
        end
        ST_SEL_WAIT: begin
          if (sel_ready) begin
            state_nxt = ST_IDLE;
            sel_done  = 1'b1;
          end
        end
        ST_LOCKED: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and button history; history tracks every cycle so no edge goes stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      btn_prev <= 5'b11111;
    end else begin
      state    <= state_nxt;
      btn_prev <= btn_now;
    end
  end

  // Cursor register; moved pulses with the new position, never on a clamped no-op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_x <= XW'(START_X);
      cursor_y <= YW'(START_Y);
      moved    <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (step_en && ((x_nxt != cursor_x) || (y_nxt != cursor_y))) begin
        cursor_x <= x_nxt;
        cursor_y <= y_nxt;
        moved    <= 1'b1;
      end
    end
  end

  // Selection register: latch on take, clear on accept or lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_valid <= 1'b0;
      sel_x     <= '0;
      sel_y     <= '0;
    end else if (sel_take) begin
      sel_valid <= 1'b1;
      sel_x     <= cursor_x;
      sel_y     <= cursor_y;
    end else if (lock || sel_done) begin
      sel_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buscaminas_cursor.sv
// tb_buscaminas_cursor: directed bench driving two cursor instances on an
// 8x8 board, one wrapping (_w) and one saturating (_s), checked every cycle
// against a position/selection model plus hand-computed spot checks.
module tb_buscaminas_cursor;

  localparam int COLS = 8;
  localparam int ROWS = 8;

  localparam logic [4:0] UP    = 5'b00001;
  localparam logic [4:0] DOWN  = 5'b00010;
  localparam logic [4:0] LEFT  = 5'b00100;
  localparam logic [4:0] RIGHT = 5'b01000;
  localparam logic [4:0] SEL   = 5'b10000;
  localparam logic [4:0] NONE  = 5'b00000;

  logic clk = 1'b0;
  logic rst, lock, sel_ready;
  logic btn_up, btn_down, btn_left, btn_right, btn_sel;

  logic [2:0] cx_w, cy_w, sx_w, sy_w, cx_s, cy_s, sx_s, sy_s;
  logic       mv_w, sv_w, mv_s, sv_s;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  buscaminas_cursor #(.COLS(COLS), .ROWS(ROWS), .START_X(0), .START_Y(0), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .lock(lock),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .sel_ready(sel_ready),
    .cursor_x(cx_w), .cursor_y(cy_w), .moved(mv_w),
    .sel_valid(sv_w), .sel_x(sx_w), .sel_y(sy_w)
  );

  buscaminas_cursor #(.COLS(COLS), .ROWS(ROWS), .START_X(0), .START_Y(0), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .lock(lock),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .sel_ready(sel_ready),
    .cursor_x(cx_s), .cursor_y(cy_s), .moved(mv_s),
    .sel_valid(sv_s), .sel_x(sx_s), .sel_y(sy_s)
  );

  // ---------------- model ----------------
  int   m_x[2], m_y[2], m_sx[2], m_sy[2];
  bit   m_mv[2], m_sv[2];
  int   m_mode;              // 0 idle, 1 waiting for accept, 2 locked
  logic [4:0] m_prev, m_cur, m_rise;
  int   m_dx, m_dy, m_nx, m_ny;

  function automatic int step(input int v, input int d, input int n, input bit wr);
    int r;
    r = v + d;
    if (wr)           r = (r + n) % n;
    else if (r < 0)   r = 0;
    else if (r > n-1) r = n - 1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_prev = 5'b11111;
      for (int k = 0; k < 2; k++) begin
        m_x[k] = 0; m_y[k] = 0; m_mv[k] = 0; m_sv[k] = 0; m_sx[k] = 0; m_sy[k] = 0;
      end
    end else begin
      m_cur  = {btn_sel, btn_right, btn_left, btn_down, btn_up};
      m_rise = m_cur & ~m_prev;
      m_prev = m_cur;
      for (int k = 0; k < 2; k++) m_mv[k] = 0;
      if (lock) begin
        for (int k = 0; k < 2; k++) m_sv[k] = 0;
        m_mode = 2;
      end else if (m_mode == 0) begin
        if (m_rise[4]) begin
          m_mode = 1;
          for (int k = 0; k < 2; k++) begin
            m_sv[k] = 1; m_sx[k] = m_x[k]; m_sy[k] = m_y[k];
          end
        end else begin
          m_dx = int'(m_rise[3]) - int'(m_rise[2]);
          m_dy = int'(m_rise[1]) - int'(m_rise[0]);
          for (int k = 0; k < 2; k++) begin
            m_nx = step(m_x[k], m_dx, COLS, k == 0);
            m_ny = step(m_y[k], m_dy, ROWS, k == 0);
            m_mv[k] = (m_nx != m_x[k]) || (m_ny != m_y[k]);
            m_x[k] = m_nx;
            m_y[k] = m_ny;
          end
        end
      end else if (m_mode == 1) begin
        if (sel_ready) begin
          m_mode = 0;
          for (int k = 0; k < 2; k++) m_sv[k] = 0;
        end
      end else begin
        m_mode = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, 2 time units after the active edge
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      check("cursor_x_w", 32'(cx_w), m_x[0]);
      check("cursor_y_w", 32'(cy_w), m_y[0]);
      check("moved_w",    32'(mv_w), int'(m_mv[0]));
      check("sel_valid_w",32'(sv_w), int'(m_sv[0]));
      check("cursor_x_s", 32'(cx_s), m_x[1]);
      check("cursor_y_s", 32'(cy_s), m_y[1]);
      check("moved_s",    32'(mv_s), int'(m_mv[1]));
      check("sel_valid_s",32'(sv_s), int'(m_sv[1]));
      if (m_sv[0]) begin
        check("sel_x_w", 32'(sx_w), m_sx[0]);
        check("sel_y_w", 32'(sy_w), m_sy[0]);
        check("sel_x_s", 32'(sx_s), m_sx[1]);
        check("sel_y_s", 32'(sy_s), m_sy[1]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_btn(input logic [4:0] b);
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  // One-cycle press; returns on the negedge after the sampling posedge
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    set_btn(b);
    @(negedge clk);
    set_btn(NONE);
  endtask

  task automatic do_reset(input logic [4:0] held);
    @(negedge clk);
    set_btn(held);
    rst = 1'b1; lock = 1'b0; sel_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic accept_pulse();
    @(negedge clk);
    sel_ready = 1'b1;
    @(negedge clk);
    sel_ready = 1'b0;
  endtask

  // {lock, sel_ready, sel, right, left, down, up}, one entry per cycle
  logic [6:0] vt[16];

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; lock = 1'b0; sel_ready = 1'b0;
    set_btn(NONE);
    vt = '{7'b0000100, 7'b0000000, 7'b0000001, 7'b0000011,
           7'b0000000, 7'b0010000, 7'b0001000, 7'b0100000,
           7'b0001000, 7'b1000000, 7'b1100100, 7'b0000100,
           7'b0000000, 7'b0000110, 7'b0110000, 7'b0100000};

    // T1: reset state, right held through reset must not step
    do_reset(RIGHT);
    repeat (2) @(negedge clk);
    check("t1_x_w", 32'(cx_w), 0);
    check("t1_y_w", 32'(cy_w), 0);
    check("t1_moved_w", 32'(mv_w), 0);
    check("t1_sel_valid_w", 32'(sv_w), 0);
    check("t1_x_s", 32'(cx_s), 0);
    set_btn(NONE);
    @(negedge clk);

    // T2: eight right edges; wrap returns to 0, saturate stops at 7
    for (int i = 1; i <= 8; i++) begin
      press(RIGHT);
      check("t2_x_w", 32'(cx_w), i % 8);
      check("t2_moved_w", 32'(mv_w), 1);
      check("t2_x_s", 32'(cx_s), (i < 7) ? i : 7);
      check("t2_moved_s", 32'(mv_s), (i <= 7) ? 1 : 0);
    end

    // T3: up at row 0, up+down cancel, diagonal right+down
    do_reset(NONE);
    press(UP);
    check("t3_up_y_w", 32'(cy_w), 7);
    check("t3_up_x_w", 32'(cx_w), 0);
    check("t3_up_y_s", 32'(cy_s), 0);
    check("t3_up_moved_s", 32'(mv_s), 0);
    press(UP | DOWN);
    check("t3_ud_y_w", 32'(cy_w), 7);
    check("t3_ud_moved_w", 32'(mv_w), 0);
    do_reset(NONE);
    press(RIGHT | DOWN);
    check("t3_diag_x_w", 32'(cx_w), 1);
    check("t3_diag_y_w", 32'(cy_w), 1);
    check("t3_diag_moved_w", 32'(mv_w), 1);
    check("t3_diag_x_s", 32'(cx_s), 1);
    check("t3_diag_y_s", 32'(cy_s), 1);
    press(LEFT | RIGHT);
    check("t3_lr_x_w", 32'(cx_w), 1);

    // T4: select at (3,5), steps ignored while pending, then accept
    do_reset(NONE);
    repeat (3) press(RIGHT);
    repeat (5) press(DOWN);
    press(SEL);
    repeat (5) press(LEFT);
    check("t4_sel_valid_w", 32'(sv_w), 1);
    check("t4_sel_x_w", 32'(sx_w), 3);
    check("t4_sel_y_w", 32'(sy_w), 5);
    check("t4_x_w", 32'(cx_w), 3);
    check("t4_y_w", 32'(cy_w), 5);
    check("t4_sel_x_s", 32'(sx_s), 3);
    accept_pulse();
    check("t4_accept_w", 32'(sv_w), 0);
    press(LEFT);
    check("t4_after_x_w", 32'(cx_w), 2);
    @(negedge clk); sel_ready = 1'b1;
    repeat (3) @(negedge clk);
    sel_ready = 1'b0;
    check("t4_idle_ready_sv", 32'(sv_w), 0);
    // select and step on the same cycle: pre-step cell, no move
    press(SEL | RIGHT);
    check("t4_sr_sel_valid", 32'(sv_w), 1);
    check("t4_sr_sel_x", 32'(sx_w), 2);
    check("t4_sr_x", 32'(cx_w), 2);
    check("t4_sr_moved", 32'(mv_w), 0);
    accept_pulse();

    // T5: lock drops pending select and freezes the cursor
    press(SEL);
    check("t5_sel_valid", 32'(sv_w), 1);
    @(negedge clk); lock = 1'b1;
    @(negedge clk);
    check("t5_lock_clear", 32'(sv_w), 0);
    press(RIGHT);
    accept_pulse();
    check("t5_lock_x", 32'(cx_w), 2);
    @(negedge clk); set_btn(RIGHT);
    @(negedge clk); lock = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_stale_x", 32'(cx_w), 2);
    set_btn(NONE);
    press(RIGHT);
    check("t5_unlock_x", 32'(cx_w), 3);
    check("t5_unlock_moved", 32'(mv_w), 1);

    // Async reset while a selection is pending
    press(SEL);
    check("t6_sel_valid", 32'(sv_w), 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_sv", 32'(sv_w), 0);
    check("t6_rst_x", 32'(cx_w), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Mixed directed vectors, checked by the per-cycle model
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      {lock, sel_ready} = vt[i][6:5];
      set_btn(vt[i][4:0]);
    end
    @(negedge clk);
    lock = 1'b0; sel_ready = 1'b0; set_btn(NONE);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
